// File: rtl/msrv32_pc_unit.sv
// Program-counter stage: next-PC selection, architectural PC register, redirect buffering
// across instruction-bus stalls, and the boot sequencer. Optional macro: MSRV32_MISALIGN_TRAP_EN.
module msrv32_pc_unit #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [1:0]  pc_src_in,
    input  logic        branch_taken_in,
    input  logic [30:0] iaddr_in,
    input  logic [31:0] epc_in,
    input  logic [31:0] trap_address_in,
    input  logic        ahb_ready_in,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus_4_out,
    output logic [31:0] pc_mux_out,
    output logic [31:0] iaddr_out,
    output logic        fetch_valid_out,
    output logic        misaligned_instr_out
);

    localparam logic [1:0] SRC_BOOT = 2'b00;
    localparam logic [1:0] SRC_MRET = 2'b01;
    localparam logic [1:0] SRC_TRAP = 2'b10;
    localparam logic [1:0] SRC_SEQ  = 2'b11;

    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_BOOT  = 2'b01,
        ST_RUN   = 2'b10
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] redirect_addr;
    logic        pending;
    logic [31:0] branch_addr;
    logic        redirect;
    logic        candidate;
    logic        suppress;

    function automatic logic [31:0] branch_target(input logic [30:0] addr);
`ifdef MSRV32_MISALIGN_TRAP_EN
        return {addr, 1'b0};
`else
        // Without the misalignment trap, halfword targets are rounded down to a word.
        return {addr[30:1], 2'b00};
`endif
    endfunction

    assign pc_plus_4_out = pc_out + 32'd4;
    assign branch_addr   = branch_target(iaddr_in);

    always_comb begin
        pc_mux_out = pc_plus_4_out;
        case (pc_src_in)
            SRC_BOOT: pc_mux_out = BOOT_ADDRESS;
            SRC_MRET: pc_mux_out = epc_in;
            SRC_TRAP: pc_mux_out = trap_address_in;
            default:  pc_mux_out = branch_taken_in ? branch_addr : pc_plus_4_out;
        endcase
    end

    assign redirect  = (pc_src_in != SRC_SEQ) | branch_taken_in;
    assign candidate = (pc_src_in == SRC_SEQ) & branch_taken_in & iaddr_in[0];

`ifdef MSRV32_MISALIGN_TRAP_EN
    assign misaligned_instr_out = (state == ST_RUN) & candidate;
`else
    logic unused_candidate;
    assign unused_candidate     = candidate;
    assign misaligned_instr_out = 1'b0;
`endif

    // A misaligned target is dropped; a redirect already buffered still takes precedence.
    assign suppress = misaligned_instr_out & ~pending;

    always_comb begin
        iaddr_out = BOOT_ADDRESS;
        if (state == ST_RUN) begin
            iaddr_out = pending ? redirect_addr : pc_mux_out;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RESET: state_next = ST_BOOT;
            ST_BOOT:  state_next = ahb_ready_in ? ST_RUN : ST_BOOT;
            ST_RUN:   state_next = ST_RUN;
            default:  state_next = ST_RESET;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state           <= ST_RESET;
            fetch_valid_out <= 1'b0;
            pc_out          <= BOOT_ADDRESS;
            pending         <= 1'b0;
            redirect_addr   <= 32'd0;
        end else begin
            state           <= state_next;
            fetch_valid_out <= 1'b1;
            case (state)
                ST_BOOT: begin
                    if (ahb_ready_in) begin
                        pc_out <= BOOT_ADDRESS;
                    end
                end
                ST_RUN: begin
                    if (ahb_ready_in) begin
                        if (!suppress) begin
                            pc_out <= iaddr_out;
                        end
                        pending <= 1'b0;
                    end else if (!pending) begin
                        if (redirect && !suppress) begin
                            redirect_addr <= pc_mux_out;
                            pending       <= 1'b1;
                        end
                    end else if (pc_src_in == SRC_MRET || pc_src_in == SRC_TRAP) begin
                        // A stalled decode re-presents its branch, so only mret/trap may replace the buffer.
                        redirect_addr <= pc_mux_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/msrv32_pc_unit.md
# msrv32_pc_unit

Program-counter stage of the msrv32 core, directly downstream of `msrv32_branch_unit`. It consumes `branch_taken_out` together with the immediate-adder target, the trap and mret vectors, and instruction-bus readiness. From these it selects the next fetch address, holds the architectural PC in a register, and buffers any redirect that arrives while the instruction bus is stalled. It also contains a small boot FSM that sequences the first fetch after reset.

## Interface
Parameters:
- `BOOT_ADDRESS`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `ms_riscv32_mp_clk_in`  in  1  core clock; all state updates on the rising edge.
- `ms_riscv32_mp_rst_in`  in  1  reset, synchronous, active-high.
- `pc_src_in`  in  2  next-PC source:
  - 00: boot.
  - 01: mret, uses `epc_in`.
  - 10: trap, uses `trap_address_in`.
  - 11: sequential or branch.
- `branch_taken_in`  in  1  from `msrv32_branch_unit.branch_taken_out`.
- `iaddr_in`  in  31  branch/jump target bits [31:1]; target = {iaddr_in, 1'b0}.
- `epc_in`  in  32  mret return address.
- `trap_address_in`  in  32  trap vector.
- `ahb_ready_in`  in  1  instruction bus accepts `iaddr_out` this cycle.
- `pc_out`  out  32  registered PC of the instruction in decode.
- `pc_plus_4_out`  out  32  pc_out + 4, modulo 2^32.
- `pc_mux_out`  out  32  combinational next-PC selection, before redirect buffering.
- `iaddr_out`  out  32  fetch address presented to the bus.
- `fetch_valid_out`  out  1  `iaddr_out` is a real request.
- `misaligned_instr_out`  out  1  taken target not 4-byte aligned.

## Operation
FSM states:
- **RESET**: entered whenever rst=1.
  - First cycle with rst=0 → BOOT.
- **BOOT**:
  - iaddr_out = BOOT_ADDRESS; fetch_valid_out = 1.
  - If ahb_ready_in = 1: pc_out <= BOOT_ADDRESS, go to RUN.
  - Otherwise stay in BOOT.
- **RUN**: selection for pc_mux_out:
  - 00 → BOOT_ADDRESS.
  - 01 → epc_in.
  - 10 → trap_address_in.
  - 11 → {iaddr_in,1'b0} if branch_taken_in, else pc_plus_4_out.
- A *redirect* is any selection other than pc_plus_4_out.
- Redirect buffer: register `redirect_addr` plus flag `pending`.
  - iaddr_out = pending ? redirect_addr : pc_mux_out.
  - **ahb_ready_in=1**: pc_out <= iaddr_out; pending <= 0.
  - **ahb_ready_in=0, pending=0, redirect present**: redirect_addr <= pc_mux_out; pending <= 1; pc_out holds.
  - **ahb_ready_in=0, pending=1**: pc_src_in 01 or 10 overwrites redirect_addr. A branch redirect is ignored, because the stalled decode re-presents the same branch.
  - **ahb_ready_in=0, no redirect**: all state holds.
- Arithmetic: pc_plus_4_out wraps, so 32'hFFFF_FFFC + 4 = 0. Targets are never sign-extended or modified here.
- Misalignment: candidate = pc_src_in=11 & branch_taken_in & iaddr_in[0] (target bit 1 set). Handling depends on configuration; see below.

## Timing
- Reset values:
  - pc_out = BOOT_ADDRESS.
  - pc_plus_4_out = BOOT_ADDRESS+4.
  - iaddr_out = BOOT_ADDRESS.
  - fetch_valid_out = 0; misaligned_instr_out = 0.
  - pending = 0; redirect_addr = 0; state RESET.
- fetch_valid_out is registered: 0 in RESET, 1 in BOOT and RUN.
- pc_mux_out and iaddr_out are combinational from inputs and state. pc_out updates 1 cycle after a ready fetch.
- Minimum after reset release: 1 cycle RESET→BOOT, then BOOT→RUN on the first ready cycle.
- Reset asserted mid-stall clears pending and returns to RESET on the next edge; the buffered redirect is lost.
- Simultaneous redirect and ahb_ready_in=1: the redirect is applied directly and pending stays 0.

## Configuration
- `MSRV32_MISALIGN_TRAP_EN` defined:
  - misaligned_instr_out = candidate, combinational, in RUN only.
  - When asserted, the redirect is suppressed: pc_out holds and nothing is buffered.
  - The trap unit then drives pc_src_in=10 on the next cycle.
- Undefined:
  - misaligned_instr_out is tied 0.
  - Target bit 1 is forced to 0, so target = {iaddr_in[30:1],2'b00}.

## Test plan
- Reset with BOOT_ADDRESS=32'h0000_1000, release, ahb_ready=1 → iaddr_out=32'h1000 with fetch_valid=1; the next edge gives pc_out=32'h1000, then 32'h1004 and 32'h1008 on the following cycles.
- RUN, pc_out=32'h100, pc_src=11, branch_taken=1, iaddr_in=31'h0000_0100 → pc_mux_out=32'h200; next edge pc_out=32'h200.
- Same branch with ahb_ready=0 for 3 cycles → pending=1 and pc_out holds at 32'h100; iaddr_out stays 32'h200 after branch_taken drops; pc_out=32'h200 the edge after ready returns.
- Stall with a branch pending, then pc_src=10, trap_address=32'h8000_0000 → iaddr_out=32'h8000_0000; this is the committed address on ready.
- pc_out=32'hFFFF_FFFC, sequential, ready → pc_out=32'h0000_0000.
- Taken target 32'h0000_0102:
  - With the macro: misaligned_instr_out=1 and pc_out holds.
  - Without: misaligned=0 and pc_out=32'h0000_0100.
